instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/instr_ram.sv | 50 +++++
 rtl/instr_loader.sv | 192 +++++++++++++++++++
 tb/tb_instr_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the instruction loader and its storage.
//   INSTR_W  : instruction word width (16)
//   ADDR_W   : instruction memory address width (5)
//   DEPTH    : number of instruction words (32)
//   loader_state_e : loader FSM state encoding
// Helper functions decode which states accept a byte and which hold the CPU.
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 5;
  localparam int DEPTH   = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RECV_HI = 3'd1,
    RECV_LO = 3'd2,
    WRITE   = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5
  } loader_state_e;

  // States in which the loader is willing to take a byte from the stream.
  function automatic logic accepts_byte(input loader_state_e st);
    case (st)
      RECV_HI, RECV_LO, CHECK: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  // States in which a load is in progress and the CPU must be held.
  function automatic logic holds_cpu(input loader_state_e st);
    case (st)
      IDLE, DONE: return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/instr_ram.sv
// -----------------------------------------------------------------------------
// instr_ram
// DEPTH x INSTR_W instruction storage, synchronous write, registered read.
// Contents are never reset. The read register has a synchronous clear that
// takes priority over a read, used to force the fetched word to zero.
// Ports:
//   clk         : clock
//   we/waddr/wdata : write port
//   re/raddr    : read request and address (data valid next cycle)
//   clr         : clear the read register to zero
//   rdata       : registered read data
// -----------------------------------------------------------------------------
module instr_ram
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic               clr,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem_r [DEPTH];
  logic [INSTR_W-1:0] rdata_r;

  // Write port; storage deliberately has no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port with priority clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata_r <= {INSTR_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Loads a program from a byte stream (high byte first, 64 bytes) into the
// instruction memory, then serves CPU fetches with one cycle of latency.
// Optional macro LOADER_CHECKSUM_EN: a 65th byte carries the XOR of the 64
// program bytes; a mismatch raises load_err instead of load_done.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   load_start          : pulse that starts a load (from IDLE or DONE only)
//   rx_data/rx_valid    : byte stream in; rx_ready says a byte is taken
//   rom_enable, pc      : fetch request and address
//   instr               : fetched word, zero while loading
//   loading             : load in progress, hold the CPU
//   load_done, load_err : sticky completion / checksum error flags
//   word_count          : words written in the current load (0..32)
// -----------------------------------------------------------------------------
module instr_loader
  import cpu_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  input  logic               rom_enable,
  input  logic [ADDR_W-1:0]  pc,
  output logic [INSTR_W-1:0] instr,
  output logic               loading,
  output logic               load_done,
  output logic               load_err,
  output logic [5:0]         word_count
);

  loader_state_e     state_r, state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [5:0]        word_count_r;
  logic [7:0]        hi_r, lo_r;
  logic              rx_ready_r, loading_r, load_done_r;
  logic              xfer_s, last_word_s, start_ok_s;
  logic              ram_we_s, ram_re_s, ram_clr_s;
  logic [INSTR_W-1:0] ram_q;

  assign xfer_s      = rx_valid & rx_ready_r;
  // The write in progress is the final one when 31 words are already stored.
  assign last_word_s = (word_count_r >= 6'(DEPTH - 1));
  assign start_ok_s  = load_start & ((state_r == IDLE) | (state_r == DONE));

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_start) state_s = RECV_HI;
        else            state_s = IDLE;
      end
      RECV_HI: begin
        if (xfer_s) state_s = RECV_LO;
        else        state_s = RECV_HI;
      end
      RECV_LO: begin
        if (xfer_s) state_s = WRITE;
        else        state_s = RECV_LO;
      end
      WRITE: begin
        if (!last_word_s) begin
          state_s = RECV_HI;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_s = CHECK;
`else
          state_s = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer_s) state_s = DONE;
        else        state_s = CHECK;
      end
`endif
      DONE: begin
        if (load_start) state_s = RECV_HI;
        else            state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_r;
  logic       load_err_r;

  // Running XOR of program bytes and the error flag from the check byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_r     <= 8'h00;
      load_err_r <= 1'b0;
    end else if (start_ok_s) begin
      csum_r     <= 8'h00;
      load_err_r <= 1'b0;
    end else if (xfer_s && ((state_r == RECV_HI) || (state_r == RECV_LO))) begin
      csum_r <= csum_r ^ rx_data;
    end else if (xfer_s && (state_r == CHECK)) begin
      load_err_r <= (rx_data != csum_r);
    end
  end

  assign load_err = load_err_r;
`else
  assign load_err = 1'b0;
`endif

  // State register, registered status outputs and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      word_count_r <= 6'd0;
      hi_r         <= 8'h00;
      lo_r         <= 8'h00;
      rx_ready_r   <= 1'b0;
      loading_r    <= 1'b0;
      load_done_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      rx_ready_r <= accepts_byte(state_s);
      loading_r  <= holds_cpu(state_s);
      case (state_r)
        IDLE, DONE: begin
          if (start_ok_s) begin
            addr_r       <= {ADDR_W{1'b0}};
            word_count_r <= 6'd0;
            load_done_r  <= 1'b0;
          end
        end
        RECV_HI: begin
          if (xfer_s) hi_r <= rx_data;
        end
        RECV_LO: begin
          if (xfer_s) lo_r <= rx_data;
        end
        WRITE: begin
          word_count_r <= word_count_r + 6'd1;
          // Address saturates at the last word rather than wrapping.
          if (!last_word_s) addr_r <= addr_r + ADDR_W'(1);
`ifndef LOADER_CHECKSUM_EN
          if (last_word_s) load_done_r <= 1'b1;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer_s) load_done_r <= (rx_data == csum_r);
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Fetch reads only while the CPU is free; the read register is cleared
  // whenever the next cycle is a loading cycle, so instr is zero exactly
  // while loading is high and holds afterwards until the next fetch.
  assign ram_we_s  = (state_r == WRITE);
  assign ram_re_s  = rom_enable & ~loading_r;
  assign ram_clr_s = rst | holds_cpu(state_s);

  instr_ram #(
    .DEPTH   (DEPTH),
    .INSTR_W (INSTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .waddr (addr_r),
    .wdata ({hi_r, lo_r}),
    .re    (ram_re_s),
    .clr   (ram_clr_s),
    .raddr (pc),
    .rdata (ram_q)
  );

  assign rx_ready   = rx_ready_r;
  assign loading    = loading_r;
  assign load_done  = load_done_r;
  assign word_count = word_count_r;
  assign instr      = ram_q;

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
// Self-checking bench for instr_loader. A byte-counting reference model
// predicts every registered output each cycle; directed scenarios add
// hand-computed expectations. Works with or without LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_instr_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rom_enable = 1'b0;
  logic [4:0]  pc = 5'd0;
  logic        rx_ready, loading, load_done, load_err;
  logic [15:0] instr;
  logic [5:0]  word_count;

  int checks = 0;
  int failures = 0;

  instr_loader #(.DEPTH(32), .INSTR_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rom_enable (rom_enable),
    .pc         (pc),
    .instr      (instr),
    .loading    (loading),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte counting) ----------------
  logic [15:0] m_mem [32];
  bit          m_valid = 1'b0;
  bit          m_active = 1'b0;
  bit          m_wait = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          was_active;
  int          m_bytes = 0;
  int          m_words = 0;
  logic [7:0]  m_hi, m_lo;
  logic [7:0]  m_xor = 8'h00;
  logic [15:0] m_instr = 16'h0000;

  always @(posedge clk) begin
    was_active = m_active;
    if (rst) begin
      m_valid = 1'b1; m_active = 1'b0; m_wait = 1'b0;
      m_done = 1'b0; m_err = 1'b0; m_words = 0; m_instr = 16'h0000;
    end else begin
      if (!m_active) begin
        if (load_start) begin
          m_active = 1'b1; m_bytes = 0; m_words = 0; m_wait = 1'b0;
          m_done = 1'b0; m_err = 1'b0; m_xor = 8'h00;
        end
      end else if (m_wait) begin
        m_mem[m_words] = {m_hi, m_lo};
        m_words++;
        m_wait = 1'b0;
        if (m_words == 32 && !CSUM) begin
          m_active = 1'b0; m_done = 1'b1;
        end
      end else if (rx_valid) begin
        if (m_bytes < 64) begin
          if (m_bytes % 2 == 0) m_hi = rx_data;
          else begin m_lo = rx_data; m_wait = 1'b1; end
          m_xor ^= rx_data;
          m_bytes++;
        end else begin
          m_active = 1'b0;
          m_done = (rx_data == m_xor);
          m_err = !m_done;
        end
      end
      if (m_active) m_instr = 16'h0000;
      else if (rom_enable && !was_active) m_instr = m_mem[pc];
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("rx_ready",   32'(rx_ready),   32'(m_active && !m_wait));
      chk("loading",    32'(loading),    32'(m_active));
      chk("load_done",  32'(load_done),  32'(m_done));
      chk("load_err",   32'(load_err),   32'(m_err));
      chk("word_count", 32'(word_count), 32'(m_words));
      chk("instr",      32'(instr),      32'(m_instr));
    end
  end

  // Count loading cycles in which the byte stream is stalled.
  int drop_cnt = 0;
  bit drop_en = 1'b0;
  always @(negedge clk) begin
    if (drop_en && loading && !rx_ready) drop_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  logic [15:0] tx_words [32];
  logic [7:0]  tx_q [$];
  bit          rand_pc = 1'b0;
  logic [7:0]  xsum;

  task automatic build_q(input bit add_csum, input bit flip, output logic [7:0] x);
    tx_q.delete();
    x = 8'h00;
    for (int i = 0; i < 32; i++) begin
      tx_q.push_back(tx_words[i][15:8]);
      tx_q.push_back(tx_words[i][7:0]);
      x ^= tx_words[i][15:8] ^ tx_words[i][7:0];
    end
    if (add_csum) tx_q.push_back(flip ? (x ^ 8'h01) : x);
  endtask

  task automatic start_load();
    @(negedge clk); load_start = 1'b1;
    @(negedge clk); load_start = 1'b0;
  endtask

  // mode 0: valid always high, 1: toggling, 2: random gaps.
  task automatic send(input int mode, input int ls_at);
    int idx; int guard; bit ls_done;
    idx = 0; guard = 0; ls_done = 1'b0;
    while (idx < tx_q.size() && guard < 4000) begin
      @(negedge clk);
      if (rand_pc) pc = 5'($urandom_range(0, 31));
      if (!ls_done && idx == ls_at) begin load_start = 1'b1; ls_done = 1'b1; end
      else load_start = 1'b0;
      case (mode)
        0:       rx_valid = 1'b1;
        1:       rx_valid = guard[0];
        default: rx_valid = ($urandom_range(0, 2) != 0);
      endcase
      rx_data = tx_q[idx];
      if (rx_valid && rx_ready) idx++;
      guard++;
    end
    @(negedge clk);
    rx_valid = 1'b0; load_start = 1'b0;
    if (guard >= 4000) chk("send_timeout", 32'(idx), 32'(tx_q.size()));
  endtask

  task automatic fetch(input logic [4:0] a, input logic [15:0] exp, input string name);
    @(negedge clk); rom_enable = 1'b1; pc = a;
    @(negedge clk); rom_enable = 1'b0;
    chk(name, 32'(instr), 32'(exp));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [4:0] a;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_loading",  32'(loading),    32'd0);
    chk("rst_rx_ready", 32'(rx_ready),   32'd0);
    chk("rst_instr",    32'(instr),      32'h0000);
    chk("rst_wc",       32'(word_count), 32'd0);
    chk("rst_done",     32'(load_done),  32'd0);
    chk("rst_err",      32'(load_err),   32'd0);

    // Continuous load of 0xE001+i.
    for (int i = 0; i < 32; i++) tx_words[i] = 16'hE001 + 16'(i);
    build_q(CSUM, 1'b0, xsum);
    drop_cnt = 0; drop_en = 1'b1;
    start_load(); send(0, -1); repeat (3) @(negedge clk);
    drop_en = 1'b0;
    chk("write_stall_cycles", 32'(drop_cnt), 32'd32);
    chk("full_done", 32'(load_done),  32'd1);
    chk("full_err",  32'(load_err),   32'd0);
    chk("full_wc",   32'(word_count), 32'd32);
    fetch(5'd5,  16'hE006, "fetch_pc5");
    fetch(5'd0,  16'hE001, "fetch_pc0");
    fetch(5'd31, 16'hE020, "fetch_pc31");

    // rom_enable held high through a load of random words.
    for (int i = 0; i < 32; i++) tx_words[i] = 16'($urandom);
    build_q(CSUM, 1'b0, xsum);
    rom_enable = 1'b1; pc = 5'd2;
    start_load();
    chk("instr_zero_loading", 32'(instr), 32'h0000);
    rand_pc = 1'b1;
    send(2, -1);
    repeat (10) begin @(negedge clk); pc = 5'($urandom_range(0, 31)); end
    rand_pc = 1'b0; rom_enable = 1'b0;
    fetch(5'd17, tx_words[17], "fetch_rand17");

    // Toggling rx_valid, same program as the continuous load.
    for (int i = 0; i < 32; i++) tx_words[i] = 16'hE001 + 16'(i);
    build_q(CSUM, 1'b0, xsum);
    start_load(); send(1, -1); repeat (3) @(negedge clk);
    chk("toggle_wc", 32'(word_count), 32'd32);
    for (int i = 0; i < 32; i++) fetch(5'(i), 16'hE001 + 16'(i), "toggle_mem");

    // load_start pulsed at word 7 is ignored.
    for (int i = 0; i < 32; i++) tx_words[i] = 16'hB000 + 16'(i);
    build_q(CSUM, 1'b0, xsum);
    start_load(); send(0, 14); repeat (3) @(negedge clk);
    chk("midstart_wc",   32'(word_count), 32'd32);
    chk("midstart_done", 32'(load_done),  32'd1);
    fetch(5'd7, 16'hB007, "midstart_pc7");

    // Reset after word 10: partial contents retained.
    for (int i = 0; i < 32; i++) tx_words[i] = 16'hA000 + 16'(i);
    build_q(1'b0, 1'b0, xsum);
    while (tx_q.size() > 20) void'(tx_q.pop_back());
    start_load(); send(0, -1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_loading", 32'(loading),    32'd0);
    chk("midrst_done",    32'(load_done),  32'd0);
    chk("midrst_wc",      32'(word_count), 32'd0);
    fetch(5'd3,  16'hA003, "midrst_pc3");
    fetch(5'd9,  16'hA009, "midrst_pc9");
    fetch(5'd10, 16'hB00A, "midrst_pc10");

`ifdef LOADER_CHECKSUM_EN
    // Checksum byte correct, then with bit 0 flipped.
    for (int i = 0; i < 32; i++) tx_words[i] = 16'hE001 + 16'(i);
    build_q(1'b1, 1'b0, xsum);
    chk("csum_value", 32'(xsum), 32'h20);
    start_load(); send(0, -1); repeat (3) @(negedge clk);
    chk("csum_ok_done", 32'(load_done), 32'd1);
    chk("csum_ok_err",  32'(load_err),  32'd0);
    build_q(1'b1, 1'b1, xsum);
    start_load(); send(2, -1); repeat (3) @(negedge clk);
    chk("csum_bad_done", 32'(load_done), 32'd0);
    chk("csum_bad_err",  32'(load_err),  32'd1);
`endif

    // Random programs with random gaps.
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 32; i++) tx_words[i] = 16'($urandom);
      build_q(CSUM, 1'b0, xsum);
      start_load(); send(int'($urandom_range(0, 2)), -1); repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        a = 5'($urandom_range(0, 31));
        fetch(a, tx_words[a], "rand_fetch");
      end
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
